// File: rtl/lsu_pkg.sv
// Shared types and helpers for the rv32i load/store unit.
// LSU_MISALIGNED_EN adds the BEAT1 state used by split accesses.
package lsu_pkg;

  localparam int unsigned LSU_MAX_LANES = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

`ifdef LSU_MISALIGNED_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_RESP  = 2'd3
  } lsu_state_t;
`endif

  // Byte lanes per bus beat.
  function automatic int unsigned lsu_lanes(input int unsigned xlen);
    return xlen / 32'd8;
  endfunction

  // Active lanes for beat0 (off..end clipped at the beat) or beat1 (overflow from lane 0).
  function automatic logic [LSU_MAX_LANES-1:0] lsu_be_mask(input int unsigned lanes,
                                                           input int unsigned off,
                                                           input lsu_size_t   size,
                                                           input logic        beat1);
    int unsigned nbytes;
    int unsigned lo;
    int unsigned hi;
    logic [LSU_MAX_LANES-1:0] m;
    nbytes = 32'd1 << size;
    if (beat1) begin
      lo = 32'd0;
      hi = (off + nbytes > lanes) ? (off + nbytes - lanes) : 32'd0;
    end else begin
      lo = off;
      hi = (off + nbytes > lanes) ? lanes : (off + nbytes);
    end
    for (int unsigned i = 0; i < LSU_MAX_LANES; i++) begin
      m[i] = (i >= lo) && (i < hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store shift/byte enables and load extraction/extension.
// LSU_MISALIGNED_EN adds the beat1 store half and partial-register load assembly.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int unsigned XLEN   = 32,
  localparam int unsigned LANES  = lsu_lanes(XLEN),
  localparam int unsigned LANE_W = $clog2(LANES)
) (
  input  logic [LANE_W-1:0] i_req_off,
  input  lsu_size_t         i_req_size,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic [LANES-1:0]  o_be0_c,
  output logic [XLEN-1:0]   o_wdata0_c,
`ifdef LSU_MISALIGNED_EN
  output logic              o_split_c,
  output logic [LANES-1:0]  o_be1_c,
  output logic [XLEN-1:0]   o_wdata1_c,
  input  logic              i_ld_beat1,
  input  logic [XLEN-1:0]   i_partial,
  output logic [XLEN-1:0]   o_partial_c,
`else
  output logic              o_misalign_c,
`endif
  input  logic [LANE_W-1:0] i_ld_off,
  input  lsu_size_t         i_ld_size,
  input  logic              i_ld_unsigned,
  input  logic [XLEN-1:0]   i_rddata,
  output logic [XLEN-1:0]   o_rdata_c
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_raw;
  logic            w_sign;
  int unsigned     w_nbits;

  assign o_be0_c   = LANES'(lsu_be_mask(LANES, 32'(i_req_off), i_req_size, 1'b0));
  assign w_shifted = i_rddata >> {i_ld_off, 3'b000};

`ifdef LSU_MISALIGNED_EN
  logic [2*XLEN-1:0] w_wide;
  int unsigned       w_hi_sh;

  // Bytes pushed past the top lane become the beat1 store data.
  assign w_wide     = {{XLEN{1'b0}}, i_req_wdata} << {i_req_off, 3'b000};
  assign o_wdata0_c = w_wide[XLEN-1:0];
  assign o_wdata1_c = w_wide[2*XLEN-1:XLEN];
  assign o_be1_c    = LANES'(lsu_be_mask(LANES, 32'(i_req_off), i_req_size, 1'b1));
  assign o_split_c  = (32'(i_req_off) + (32'd1 << i_req_size)) > LANES;

  assign w_hi_sh     = (LANES - 32'(i_ld_off)) * 32'd8;
  assign o_partial_c = w_shifted;
  assign w_raw       = i_ld_beat1 ? (i_partial | (i_rddata << w_hi_sh)) : w_shifted;
`else
  assign o_wdata0_c   = i_req_wdata << {i_req_off, 3'b000};
  assign o_misalign_c = (32'(i_req_off) & ((32'd1 << i_req_size) - 32'd1)) != 32'd0;
  assign w_raw        = w_shifted;
`endif

  // Sign- or zero-extend from the top bit of the accessed size.
  always_comb begin
    w_sign  = 1'b0;
    w_nbits = XLEN;
    case (i_ld_size)
      SZ_B: begin w_sign = w_raw[7];  w_nbits = 32'd8;  end
      SZ_H: begin w_sign = w_raw[15]; w_nbits = 32'd16; end
      SZ_W: begin w_sign = w_raw[31]; w_nbits = 32'd32; end
      default: begin w_sign = w_raw[XLEN-1]; w_nbits = XLEN; end
    endcase
    w_sign = w_sign & ~i_ld_unsigned;
    for (int unsigned i = 0; i < XLEN; i++) begin
      o_rdata_c[i] = (i < w_nbits) ? w_raw[i] : w_sign;
    end
  end

endmodule

// File: rtl/rv32i_lsu.sv
// Handshaked load/store unit between the core MEM stage and the data bus.
// Define LSU_MISALIGNED_EN to split boundary-crossing accesses into two beats.
module rv32i_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN-1:0]     bus_wrdata,
  output logic [XLEN/8-1:0]   bus_byteen,
  output logic                bus_wren,
  output logic                bus_rden,
  input  logic                bus_ack,
  input  logic [XLEN-1:0]     bus_rddata
);

  localparam int unsigned LSU_LANES = lsu_lanes(XLEN);
  localparam int unsigned LANE_W    = $clog2(LSU_LANES);
  localparam int unsigned TCNT_W    = 10;

  lsu_state_t          r_state;
  logic                r_store;
  lsu_size_t           r_size;
  logic                r_unsigned;
  logic [LANE_W-1:0]   r_off;
  logic [TCNT_W-1:0]   r_tcnt;

  lsu_size_t           w_size;
  logic [LANE_W-1:0]   w_off;
  logic [ADDR_W-1:0]   w_aligned;
  logic                w_illegal;
  logic                w_err;
  logic [LSU_LANES-1:0] w_be0;
  logic [XLEN-1:0]     w_wdata0;
  logic [XLEN-1:0]     w_ld_rdata;
  logic                w_limit;

  assign w_size    = lsu_size_t'(req_size);
  assign w_off     = req_addr[LANE_W-1:0];
  assign w_aligned = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign w_illegal = (XLEN == 32) && (w_size == SZ_D);
  assign w_limit   = r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1);

`ifdef LSU_MISALIGNED_EN
  logic                 r_split;
  logic [LSU_LANES-1:0] r_be1;
  logic [XLEN-1:0]      r_wdata1;
  logic [XLEN-1:0]      r_partial;
  logic                 w_split;
  logic [LSU_LANES-1:0] w_be1;
  logic [XLEN-1:0]      w_wdata1;
  logic [XLEN-1:0]      w_ld_partial;

  assign w_err = w_illegal;
`else
  logic                 w_misalign;

  assign w_err = w_illegal | w_misalign;
`endif

  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_req_off     (w_off),
    .i_req_size    (w_size),
    .i_req_wdata   (req_wdata),
    .o_be0_c       (w_be0),
    .o_wdata0_c    (w_wdata0),
`ifdef LSU_MISALIGNED_EN
    .o_split_c     (w_split),
    .o_be1_c       (w_be1),
    .o_wdata1_c    (w_wdata1),
    .i_ld_beat1    (r_state == ST_BEAT1),
    .i_partial     (r_partial),
    .o_partial_c   (w_ld_partial),
`else
    .o_misalign_c  (w_misalign),
`endif
    .i_ld_off      (r_off),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_rddata      (bus_rddata),
    .o_rdata_c     (w_ld_rdata)
  );

  // Request FSM; every bus and response output is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      bus_addr   <= '0;
      bus_wrdata <= '0;
      bus_byteen <= '0;
      bus_wren   <= 1'b0;
      bus_rden   <= 1'b0;
      r_store    <= 1'b0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_off      <= '0;
      r_tcnt     <= '0;
`ifdef LSU_MISALIGNED_EN
      r_split    <= 1'b0;
      r_be1      <= '0;
      r_wdata1   <= '0;
      r_partial  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            r_store    <= req_store;
            r_size     <= w_size;
            r_unsigned <= req_unsigned;
            r_off      <= w_off;
            r_tcnt     <= '0;
            if (w_err) begin
              r_state   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_state    <= ST_BEAT0;
              bus_addr   <= w_aligned;
              bus_byteen <= w_be0;
              bus_wrdata <= req_store ? w_wdata0 : '0;
              bus_wren   <= req_store;
              bus_rden   <= ~req_store;
`ifdef LSU_MISALIGNED_EN
              r_split    <= w_split;
              r_be1      <= w_be1;
              r_wdata1   <= req_store ? w_wdata1 : '0;
`endif
            end
          end
        end

`ifdef LSU_MISALIGNED_EN
        ST_BEAT0, ST_BEAT1: begin
`else
        ST_BEAT0: begin
`endif
          // An ack on the same edge as the timeout limit still completes the beat.
          if (bus_ack || w_limit) begin
`ifdef LSU_MISALIGNED_EN
            if (bus_ack && (r_state == ST_BEAT0) && r_split) begin
              r_state    <= ST_BEAT1;
              bus_addr   <= bus_addr + ADDR_W'(LSU_LANES);
              bus_byteen <= r_be1;
              bus_wrdata <= r_wdata1;
              r_partial  <= w_ld_partial;
              r_tcnt     <= '0;
            end else
`endif
            begin
              r_state    <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= ~bus_ack;
              rsp_rdata  <= (bus_ack && !r_store) ? w_ld_rdata : '0;
              bus_addr   <= '0;
              bus_wrdata <= '0;
              bus_byteen <= '0;
              bus_wren   <= 1'b0;
              bus_rden   <= 1'b0;
            end
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end

        ST_RESP: begin
          r_state   <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end

        default: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu (XLEN=32, TIMEOUT_CYCLES=4); follows LSU_MISALIGNED_EN when defined.
module tb_rv32i_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic [3:0]  bus_byteen;
  logic        bus_wren;
  logic        bus_rden;
  logic        bus_ack;
  logic [31:0] bus_rddata;

  int n_checks;
  int n_errors;

  rv32i_lsu #(
    .XLEN           (32),
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .bus_addr     (bus_addr),
    .bus_wrdata   (bus_wrdata),
    .bus_byteen   (bus_byteen),
    .bus_wren     (bus_wren),
    .bus_rden     (bus_rden),
    .bus_ack      (bus_ack),
    .bus_rddata   (bus_rddata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for the accept edge, then scramble the request fields.
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin n_errors++; $display("FAIL issue_ready got %b want 1", req_ready); end
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0; req_store = ~st; req_size = 2'd0; req_unsigned = ~uns;
    req_addr = 32'hDEAD_BEE1; req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if ({bus_wren, bus_rden} !== 2'b00) begin n_errors++; $display("FAIL rst_strobes got %b want 00", {bus_wren, bus_rden}); end
    n_checks++; if (bus_addr !== 32'h0) begin n_errors++; $display("FAIL rst_addr got %h want 0", bus_addr); end
    n_checks++; if (bus_byteen !== 4'h0) begin n_errors++; $display("FAIL rst_byteen got %b want 0000", bus_byteen); end
    n_checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_errors++; $display("FAIL rst_rsp got %h/%b want 0/0", rsp_rdata, rsp_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_word();
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
    n_checks++; if (bus_rden !== 1'b1 || bus_wren !== 1'b0) begin n_errors++; $display("FAIL ldw_strobe got r%b w%b want r1 w0", bus_rden, bus_wren); end
    n_checks++; if (bus_addr !== 32'h100) begin n_errors++; $display("FAIL ldw_addr got %h want 100", bus_addr); end
    n_checks++; if (bus_byteen !== 4'b1111) begin n_errors++; $display("FAIL ldw_byteen got %b want 1111", bus_byteen); end
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL ldw_busy_ready got %b want 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL ldw_early_rsp got %b want 0", rsp_valid); end
    bus_ack = 1'b1; bus_rddata = 32'h8000_0001;
    step();
    bus_ack = 1'b0; bus_rddata = 32'h0;
    n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL ldw_rsp_valid got %b want 1", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h8000_0001) begin n_errors++; $display("FAIL ldw_rdata got %h want 80000001", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL ldw_err got %b want 0", rsp_err); end
    n_checks++; if (bus_rden !== 1'b0) begin n_errors++; $display("FAIL ldw_rden_drop got %b want 0", bus_rden); end
    step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL ldw_pulse_len got %b want 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL ldw_ready_back got %b want 1", req_ready); end
  endtask

  task automatic test_load_byte();
    for (int u = 0; u < 2; u++) begin
      issue(1'b0, 2'd0, u[0], 32'h0000_0103, 32'h0);
      n_checks++; if (bus_byteen !== 4'b1000) begin n_errors++; $display("FAIL ldb_byteen[%0d] got %b want 1000", u, bus_byteen); end
      n_checks++; if (bus_addr !== 32'h100) begin n_errors++; $display("FAIL ldb_addr[%0d] got %h want 100", u, bus_addr); end
      bus_ack = 1'b1; bus_rddata = 32'h9A00_0000;
      step();
      bus_ack = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ((u == 0) ? 32'hFFFF_FF9A : 32'h0000_009A)) begin
        n_errors++; $display("FAIL ldb_rdata[%0d] got v%b %h want v1 %h", u, rsp_valid, rsp_rdata,
                             (u == 0) ? 32'hFFFF_FF9A : 32'h0000_009A);
      end
      step();
    end
  endtask

  task automatic test_store_half();
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_BEEF);
    n_checks++; if (bus_addr !== 32'h100) begin n_errors++; $display("FAIL sth_addr got %h want 100", bus_addr); end
    n_checks++; if (bus_wrdata !== 32'hBEEF_0000) begin n_errors++; $display("FAIL sth_wrdata got %h want beef0000", bus_wrdata); end
    n_checks++; if (bus_byteen !== 4'b1100) begin n_errors++; $display("FAIL sth_byteen got %b want 1100", bus_byteen); end
    // Three wait cycles; the ack then lands on the same edge as the timeout limit.
    for (int w = 0; w < 3; w++) begin
      step();
      n_checks++;
      if (bus_wren !== 1'b1 || bus_rden !== 1'b0 || bus_wrdata !== 32'hBEEF_0000 || bus_addr !== 32'h100 || rsp_valid !== 1'b0) begin
        n_errors++; $display("FAIL sth_hold[%0d] got w%b r%b %h %h v%b want w1 r0 beef0000 100 v0",
                             w, bus_wren, bus_rden, bus_wrdata, bus_addr, rsp_valid);
      end
    end
    bus_ack = 1'b1; bus_rddata = 32'hFFFF_FFFF;
    step();
    bus_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_errors++; $display("FAIL sth_ack_wins got v%b e%b want v1 e0", rsp_valid, rsp_err); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL sth_rdata got %h want 0", rsp_rdata); end
    n_checks++; if (bus_wren !== 1'b0) begin n_errors++; $display("FAIL sth_wren_drop got %b want 0", bus_wren); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0);
    bus_ack = 1'b1; bus_rddata = 32'h8001_0000;
    step();
    bus_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_8001) begin n_errors++; $display("FAIL b2b_ldh got v%b %h want v1 ffff8001", rsp_valid, rsp_rdata); end
    step();
    issue(1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00A5);
    n_checks++; if (bus_wren !== 1'b1 || bus_wrdata !== 32'h0000_A500 || bus_byteen !== 4'b0010) begin
      n_errors++; $display("FAIL b2b_stb got w%b %h %b want w1 0000a500 0010", bus_wren, bus_wrdata, bus_byteen);
    end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_errors++; $display("FAIL b2b_stb_rsp got v%b e%b want v1 e0", rsp_valid, rsp_err); end
    step();
  endtask

  task automatic test_illegal_size();
    issue(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_errors++; $display("FAIL ill_rsp got v%b e%b want v1 e1", rsp_valid, rsp_err); end
    n_checks++; if (bus_rden !== 1'b0 || bus_wren !== 1'b0) begin n_errors++; $display("FAIL ill_strobe got r%b w%b want 0 0", bus_rden, bus_wren); end
    step();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_errors++; $display("FAIL ill_idle got v%b rdy%b want v0 rdy1", rsp_valid, req_ready); end
  endtask

  task automatic test_misaligned();
`ifdef LSU_MISALIGNED_EN
    issue(1'b0, 2'd2, 1'b0, 32'h0000_00FE, 32'h0);
    n_checks++; if (bus_addr !== 32'h0FC || bus_byteen !== 4'b1100 || bus_rden !== 1'b1) begin
      n_errors++; $display("FAIL mis_b0 got %h %b r%b want 0fc 1100 r1", bus_addr, bus_byteen, bus_rden);
    end
    bus_ack = 1'b1; bus_rddata = 32'h2211_0000;
    step();
    bus_rddata = 32'h0000_4433;
    n_checks++; if (bus_addr !== 32'h100 || bus_byteen !== 4'b0011 || bus_rden !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL mis_b1 got %h %b r%b v%b want 100 0011 r1 v0", bus_addr, bus_byteen, bus_rden, rsp_valid);
    end
    step();
    bus_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h4433_2211 || rsp_err !== 1'b0) begin
      n_errors++; $display("FAIL mis_rdata got v%b %h e%b want v1 44332211 e0", rsp_valid, rsp_rdata, rsp_err);
    end
    step();
    issue(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0);
    n_checks++; if (bus_addr !== 32'hFFFF_FFFC || bus_byteen !== 4'b1000) begin n_errors++; $display("FAIL wrap_b0 got %h %b want fffffffc 1000", bus_addr, bus_byteen); end
    bus_ack = 1'b1; bus_rddata = 32'hAB00_0000;
    step();
    bus_rddata = 32'h0000_00CD;
    n_checks++; if (bus_addr !== 32'h0 || bus_byteen !== 4'b0001) begin n_errors++; $display("FAIL wrap_b1 got %h %b want 0 0001", bus_addr, bus_byteen); end
    step();
    bus_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_CDAB) begin n_errors++; $display("FAIL wrap_rdata got v%b %h want v1 0000cdab", rsp_valid, rsp_rdata); end
    step();
`else
    issue(1'b0, 2'd2, 1'b0, 32'h0000_00FE, 32'h0);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_errors++; $display("FAIL mis_err got v%b e%b %h want v1 e1 0", rsp_valid, rsp_err, rsp_rdata);
    end
    n_checks++; if (bus_rden !== 1'b0 || bus_wren !== 1'b0) begin n_errors++; $display("FAIL mis_strobe got r%b w%b want 0 0", bus_rden, bus_wren); end
    step();
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h0000_1234);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || bus_wren !== 1'b0) begin
      n_errors++; $display("FAIL mis_h_err got v%b e%b w%b want v1 e1 w0", rsp_valid, rsp_err, bus_wren);
    end
    step();
`endif
  endtask

  task automatic test_timeout();
    bus_rddata = 32'hFFFF_FFFF;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus_rden !== 1'b1 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL to_hold[%0d] got r%b v%b want r1 v0", k, bus_rden, rsp_valid); end
      step();
    end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_errors++; $display("FAIL to_rsp got v%b e%b %h want v1 e1 0", rsp_valid, rsp_err, rsp_rdata);
    end
    n_checks++; if (bus_rden !== 1'b0) begin n_errors++; $display("FAIL to_drop got %b want 0", bus_rden); end
    step();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_errors++; $display("FAIL to_idle got v%b rdy%b want v0 rdy1", rsp_valid, req_ready); end
    bus_rddata = 32'h0;
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
    n_checks++; if (bus_rden !== 1'b1) begin n_errors++; $display("FAIL rmid_pre got %b want 1", bus_rden); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus_rden !== 1'b0) begin n_errors++; $display("FAIL rmid_async got %b want 0", bus_rden); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rmid_ready got %b want 1", req_ready); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rsp_valid !== 1'b0 || bus_rden !== 1'b0) begin n_errors++; $display("FAIL rmid_quiet[%0d] got v%b r%b want 0 0", k, rsp_valid, bus_rden); end
      step();
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rddata = 32'h0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_back_to_back();
    test_illegal_size();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
Parametrised load/store unit that replaces the core's direct bus_wren/bus_rden/bus_wrdata drive with a handshaked memory front-end.
- Accepts one load or store request at a time from the core's MEM stage.
- Handles byte-lane placement and byte enables.
- Sign- or zero-extends load data.
- Optionally splits misaligned accesses into two aligned bus beats.
- Flags bus timeout as an error.
- Sits between the core's execute/writeback muxes and the data bus.

Parameters:
XLEN, 32, data-bus and register width; legal values 32 or 64.
ADDR_W, 32, byte-address width.
TIMEOUT_CYCLES, 255, maximum cycles to wait for bus_ack before aborting a beat; legal range 1..1023.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  LSU can accept a request
req_store  in  1  1 = store, 0 = load
req_size  in  2  access size, lsu_size_t: 0=B, 1=H, 2=W, 3=D
req_unsigned  in  1  zero-extend the load result (LBU/LHU/LWU)
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  extended load data; 0 for stores
rsp_err  out  1  valid together with rsp_valid; illegal size, misaligned (feature off) or timeout
bus_addr  out  ADDR_W  aligned beat address (low log2(XLEN/8) bits = 0)
bus_wrdata  out  XLEN  lane-placed store data
bus_byteen  out  XLEN/8  active byte lanes
bus_wren  out  1  write strobe
bus_rden  out  1  read strobe
bus_ack  in  1  bus completed the current beat
bus_rddata  in  XLEN  read data; valid when bus_ack=1

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1.
  - All other outputs 0, including the timeout counter and the partial-data register.
- Request acceptance:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - The request fields are captured; the core may change them afterwards.
- States:
  - IDLE: req_ready=1; accepted request goes to BEAT0, or to RESP when the error is detected at accept time.
  - BEAT0: bus strobe held until bus_ack. On ack, goes to BEAT1 if the access is split, else RESP.
  - BEAT1: bus_addr = BEAT0 address + XLEN/8; goes to RESP on ack.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- req_ready is 0 in every state except IDLE.
- Latency:
  - Request accepted at edge N: strobe is visible in cycle N+1.
  - bus_ack sampled at edge M: rsp_valid is high in cycle M+1.
  - Aligned access with zero-wait ack: 2 cycles from accept to rsp_valid.
- Strobes: bus_wren/bus_rden are mutually exclusive and are held constant, together with address, data and byte enables, until bus_ack.
- Lane placement:
  - off = req_addr mod XLEN/8; nbytes = 1 << req_size.
  - Beat0 enables lanes off .. min(off+nbytes, XLEN/8)-1.
  - Beat1 enables lanes 0 .. remaining-1.
  - Store data is shifted left by off*8 (beat0); the upper bytes go to lane 0 onward (beat1).
- Load assembly:
  - Beat0 bytes are stored in the partial register.
  - Beat1 bytes are concatenated above them.
  - The result is sign-extended from bit nbytes*8-1 unless req_unsigned.
- Illegal size: req_size=D with XLEN=32 gives rsp_err=1 and no bus strobe.
- Timeout:
  - The counter increments each cycle a strobe is held without ack.
  - When the counter reaches TIMEOUT_CYCLES, the strobe drops, the FSM goes to RESP with rsp_err=1 and rsp_rdata=0, and any pending beat1 is skipped.
- Mid-access reset: the strobe falls immediately (asynchronous), with no response.
- Simultaneous bus_ack and timeout limit on the same edge: the ack wins.
- Address wrap: the beat1 address wraps modulo 2^ADDR_W.

Optional Feature:
LSU_MISALIGNED_EN.
- Defined: accesses crossing an XLEN/8-byte boundary are split into BEAT0+BEAT1 as above.
- Undefined:
  - No BEAT1 state exists.
  - Any access with off mod nbytes ≠ 0 completes with rsp_err=1 and no bus strobe.
  - Response takes 1 cycle after accept.

Decomposition:
- lsu_pkg:
  - lsu_size_t enum.
  - lsu_state_t enum (IDLE, BEAT0, BEAT1, RESP).
  - Function that computes the byte-enable mask from off/size.
  - Constant LSU_LANES = XLEN/8, expressed as a package function of XLEN.
- Sub-module lsu_lane_align: purely combinational.
  - Store shift and byte-enable generation.
  - Load byte extraction and sign/zero extension.
- The FSM, timeout counter and partial register stay in rv32i_lsu.

Test Plan:
- XLEN=32, load W at 0x100, bus_rddata=0x80000001, ack 0 wait -> bus_byteen=4'b1111, rsp_valid 2 cycles after accept, rsp_rdata=0x80000001, rsp_err=0.
- Load B at 0x103, unsigned=0, bus_rddata=0x9A000000 -> byteen=4'b1000, rsp_rdata=0xFFFFFF9A; same request with unsigned=1 -> 0x0000009A.
- Store H 0xBEEF at 0x102 -> bus_addr=0x100, bus_wrdata=0xBEEF0000, byteen=4'b1100, bus_wren held for 3 wait cycles until ack.
- Misaligned load W at 0x0FE, feature on:
  - Bus responses: beat0 at 0x0FC returns 0x22110000, beat1 at 0x100 returns 0x00004433.
  - Expected: rsp_rdata=0x44332211.
  - Feature off: rsp_err=1, no strobe.
- TIMEOUT_CYCLES=4, bus_ack never asserted -> strobe high for 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, FSM back in IDLE.
- Reset (rst=0) asserted while in BEAT0 -> bus_rden=0 asynchronously, req_ready=1 after release, no rsp_valid.
